// File: rtl/arith_pkg.sv
// Shared encodings for the arithmetic issue controller.
// Holds the pipeline operation modes and the sequencer states.
package arith_pkg;

    localparam logic [1:0] MODE_EXP  = 2'd0;
    localparam logic [1:0] MODE_DIV  = 2'd1;
    localparam logic [1:0] MODE_GELU = 2'd2;
    localparam logic [1:0] MODE_AGG  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        EXP    = 3'd2,
        WAIT   = 3'd3,
        DIV    = 3'd4,
        STREAM = 3'd5
    } state_t;

endpackage

// File: rtl/arith_score_buf.sv
// K x DW gating-score register file: one synchronous write port, one combinational read port.
// The data array is never reset; the controller always writes an entry before it reads it.
module arith_score_buf #(
    parameter int DW = 16,
    parameter int K  = 8,
    parameter int AW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [K];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/arith_issue_ctrl.sv
// Upstream sequencer for the arithmetic pipeline: buffers a group of gating scores, issues the
// exp+sum and divide passes with fixed spacing, then forwards expert-output elements.
module arith_issue_ctrl
    import arith_pkg::*;
#(
    parameter int DW      = 16,
    parameter int K       = 8,
    parameter int EXP_GAP = 3,
    parameter int DIV_GAP = 3,
    parameter int DRAIN   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          score_valid,
    output logic          score_ready,
    input  logic [DW-1:0] score_data,
    input  logic          score_last,
    input  logic          tok_valid,
    output logic          tok_ready,
    input  logic [DW-1:0] tok_data,
    input  logic [DW-1:0] tok_psum,
    input  logic          tok_gelu,
    output logic          arith_valid,
    output logic [DW-1:0] arith_data,
    output logic [DW-1:0] arith_psum,
    output logic [1:0]    arith_mode,
    output logic          busy,
    output logic          err_overflow,
    output logic [2:0]    dbg_state
);

    localparam int CW = $clog2(K + 1);
    localparam int AW = (K > 1) ? $clog2(K) : 1;
    localparam int GW = $clog2(EXP_GAP + DRAIN + DIV_GAP + 1);
    // Quiet cycles after the last exp issue: the normal exp spacing plus the drain window,
    // minus the cycle spent moving from WAIT into DIV.
    localparam int WAIT_LOAD = EXP_GAP + DRAIN - 2;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] idx, idx_nx;
    logic [CW-1:0] agg_left, agg_nx;
    logic [GW-1:0] gap, gap_nx;

    logic          valid_nx;
    logic [1:0]    mode_nx;
    logic [DW-1:0] data_nx;
    logic [DW-1:0] psum_nx;
    logic          ovf_nx;

    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [DW-1:0] buf_rdata;
    logic          score_hs;
    logic          tok_hs;

    // A transfer happens on a rising edge where both valid and ready are high; ready is a
    // registered copy of the state so the producer never sees it change mid-cycle.
    assign score_hs  = score_valid & score_ready;
    assign tok_hs    = tok_valid & tok_ready;
    assign dbg_state = state;

    arith_score_buf #(
        .DW (DW),
        .K  (K),
        .AW (AW)
    ) u_score_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (score_data),
        .raddr (idx[AW-1:0]),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = idx;
        agg_nx    = agg_left;
        gap_nx    = (gap != '0) ? gap - GW'(1) : '0;
        valid_nx  = 1'b0;
        mode_nx   = arith_mode;
        data_nx   = arith_data;
        psum_nx   = arith_psum;
        ovf_nx    = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = cnt[AW-1:0];

        case (state)
            IDLE: begin
                if (score_hs) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    cnt_nx    = CW'(1);
                    idx_nx    = '0;
                    gap_nx    = '0;
                    state_nx  = score_last ? EXP : FILL;
                end
            end
            FILL: begin
                if (score_hs) begin
                    buf_we = 1'b1;
                    cnt_nx = cnt + CW'(1);
                    if (score_last) begin
                        state_nx = EXP;
                    end else if (cnt == CW'(K - 1)) begin
                        state_nx = EXP;
                        ovf_nx   = 1'b1;
                    end
                end
            end
            EXP: begin
                if (gap == '0) begin
                    valid_nx = 1'b1;
                    mode_nx  = MODE_EXP;
                    data_nx  = buf_rdata;
                    psum_nx  = '0;
                    if (idx == cnt - CW'(1)) begin
                        idx_nx   = '0;
                        gap_nx   = GW'(WAIT_LOAD);
                        state_nx = WAIT;
                    end else begin
                        idx_nx = idx + CW'(1);
                        gap_nx = GW'(EXP_GAP - 1);
                    end
                end
            end
            WAIT: begin
                if (gap == '0) begin
                    state_nx = DIV;
                end
            end
            DIV: begin
                if (gap == '0) begin
                    valid_nx = 1'b1;
                    mode_nx  = MODE_DIV;
                    data_nx  = buf_rdata;
                    psum_nx  = '0;
                    if (idx == cnt - CW'(1)) begin
                        idx_nx   = '0;
                        agg_nx   = cnt;
                        state_nx = STREAM;
                    end else begin
                        idx_nx = idx + CW'(1);
                        gap_nx = GW'(DIV_GAP - 1);
                    end
                end
            end
            STREAM: begin
                if (tok_hs) begin
                    valid_nx = 1'b1;
                    data_nx  = tok_data;
                    if (tok_gelu) begin
                        mode_nx = MODE_GELU;
                        psum_nx = '0;
                    end else begin
                        mode_nx = MODE_AGG;
                        psum_nx = tok_psum;
                        agg_nx  = agg_left - CW'(1);
                        if (agg_left == CW'(1)) begin
                            cnt_nx   = '0;
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            agg_left     <= '0;
            gap          <= '0;
            arith_valid  <= 1'b0;
            arith_mode   <= '0;
            arith_data   <= '0;
            arith_psum   <= '0;
            err_overflow <= 1'b0;
            score_ready  <= 1'b0;
            tok_ready    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            idx          <= idx_nx;
            agg_left     <= agg_nx;
            gap          <= gap_nx;
            arith_valid  <= valid_nx;
            arith_mode   <= mode_nx;
            arith_data   <= data_nx;
            arith_psum   <= psum_nx;
            err_overflow <= ovf_nx;
            score_ready  <= (state_nx == IDLE) || (state_nx == FILL);
            tok_ready    <= (state_nx == STREAM);
            busy         <= (state_nx != IDLE);
        end
    end

endmodule
